vram_scanout: RTL and testbench



---
 rtl/vram_scanout_pkg.sv | 35 +++
 rtl/vram_scanout_if.sv | 24 ++
 rtl/video_timing_gen.sv | 78 +++++++
 rtl/vram_scanout.sv | 211 +++++++++++++++++++++
 tb/tb_vram_scanout.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_scanout_pkg.sv
// Shared constants and types for the VRAM scanout engine:
// default raster timing, image geometry and the reset palette.
package vram_scanout_pkg;

  localparam int DEF_WIDTH    = 128;
  localparam int DEF_HEIGHT   = 128;
  localparam int DEF_SCALE    = 3;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int DEF_ADDRESS_WIDTH =
    $clog2((DEF_WIDTH * DEF_HEIGHT + 1) >> 1);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Standard 16-colour VGA set, index 0 first.
  localparam rgb_t DEF_PAL [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

endpackage

// File: rtl/vram_scanout_if.sv
// VRAM video read port as seen by the scanout engine.
// master: drives o_mev/o_adrv, receives i_qv one clock later.
interface vram_scanout_if #(
  parameter int ADDRESS_WIDTH =
    vram_scanout_pkg::DEF_ADDRESS_WIDTH
);

  logic                     o_mev;
  logic [ADDRESS_WIDTH-1:0] o_adrv;
  logic [7:0]               i_qv;

  modport master (
    output o_mev,
    output o_adrv,
    input  i_qv
  );

  modport slave (
    input  o_mev,
    input  o_adrv,
    output i_qv
  );

endinterface

// File: rtl/video_timing_gen.sv
// Raster counters plus undelayed (stage-0) de/sync/frame_start.
// Ports: i_clk, i_rst, o_hcnt, o_vcnt, o_de, o_hsync, o_vsync,
// o_frame_start, o_line_end (last clock of line), o_frame_end.
module video_timing_gen
  import vram_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int HW =
    $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
  parameter int VW =
    $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
)(
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [HW-1:0] o_hcnt,
  output logic [VW-1:0] o_vcnt,
  output logic          o_de,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_frame_start,
  output logic          o_line_end,
  output logic          o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END =
    HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END =
    VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  logic h_in_sync;
  logic v_in_sync;

  assign h_in_sync = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign v_in_sync = (vcnt >= VS_BEG) && (vcnt < VS_END);

  assign o_hcnt        = hcnt;
  assign o_vcnt        = vcnt;
  assign o_de          = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign o_hsync       = h_in_sync ? SYNC_POL : ~SYNC_POL;
  assign o_vsync       = v_in_sync ? SYNC_POL : ~SYNC_POL;
  assign o_frame_start = (hcnt == '0) && (vcnt == '0);
  assign o_line_end    = (hcnt == H_LAST);
  assign o_frame_end   = (hcnt == H_LAST) && (vcnt == V_LAST);

endmodule

// File: rtl/vram_scanout.sv
// 4bpp VRAM scanout: scaled image fetch, palette map, RGB out.
// Ports: i_clk/i_rst, vram (master), palette write port,
// o_de/o_hsync/o_vsync/o_r/o_g/o_b/o_frame_start, 2-clock latency.
module vram_scanout
  import vram_scanout_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int SCALE    = DEF_SCALE,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int ADDRESS_WIDTH =
    $clog2((WIDTH * HEIGHT + 1) >> 1)
)(
  input  logic              i_clk,
  input  logic              i_rst,
  vram_scanout_if.master    vram,
  input  logic              i_pal_we,
  input  logic [3:0]        i_pal_idx,
  input  logic [23:0]       i_pal_data,
  output logic              o_de,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = ADDRESS_WIDTH;
  // One extra bit: the LSB of the pixel index picks the nibble.
  localparam int IW = AW + 1;
  localparam int SW = $clog2(SCALE + 1);
  localparam int YW = $clog2(HEIGHT + 1);

  localparam logic [SW-1:0] S_LAST    = SW'(SCALE - 1);
  localparam logic [YW-1:0] PY_LAST   = YW'(HEIGHT - 1);
  localparam logic [IW-1:0] LINE_STEP = IW'(WIDTH);
  localparam logic [HW-1:0] WIN_W     = HW'(WIDTH * SCALE);
  localparam logic [VW-1:0] WIN_H     = VW'(HEIGHT * SCALE);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic de0, hs0, vs0, fs0;
  logic line_end, frame_end;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_hcnt        (hcnt),
    .o_vcnt        (vcnt),
    .o_de          (de0),
    .o_hsync       (hs0),
    .o_vsync       (vs0),
    .o_frame_start (fs0),
    .o_line_end    (line_end),
    .o_frame_end   (frame_end)
  );

  // Scale sub-counters track hcnt/vcnt so that px = hcnt/SCALE
  // and line_base = (vcnt/SCALE)*WIDTH without any divider.
  logic [SW-1:0] xs;
  logic [SW-1:0] ys;
  logic [HW-1:0] px;
  logic [YW-1:0] py;
  logic [IW-1:0] line_base;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      xs        <= '0;
      ys        <= '0;
      px        <= '0;
      py        <= '0;
      line_base <= '0;
    end else if (line_end) begin
      xs <= '0;
      px <= '0;
      if (frame_end) begin
        ys        <= '0;
        py        <= '0;
        line_base <= '0;
      end else if (ys == S_LAST) begin
        ys <= '0;
        // Saturate below the image so line_base stays in range.
        if (py != PY_LAST) begin
          py        <= py + 1'b1;
          line_base <= line_base + LINE_STEP;
        end
      end else begin
        ys <= ys + 1'b1;
      end
    end else if (xs == S_LAST) begin
      xs <= '0;
      px <= px + 1'b1;
    end else begin
      xs <= xs + 1'b1;
    end
  end

  logic          win0;
  logic [IW-1:0] idx;
  logic [AW-1:0] adr_q;

  // px keeps counting past the window; the truncated index is
  // only consumed while win0 is set.
  assign win0 = (hcnt < WIN_W) && (vcnt < WIN_H);
  assign idx  = line_base + IW'(px);

  assign vram.o_mev  = win0 & ~i_rst;
  assign vram.o_adrv = vram.o_mev ? idx[AW:1] : adr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr_q <= '0;
    end else if (vram.o_mev) begin
      adr_q <= idx[AW:1];
    end
  end

  rgb_t pal [16];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) begin
        pal[i] <= DEF_PAL[i];
      end
    end else if (i_pal_we) begin
      pal[i_pal_idx] <= rgb_t'(i_pal_data);
    end
  end

  // Stage 1: window flag and nibble select wait for i_qv.
  logic win_q;
  logic odd_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      win_q <= win0;
      odd_q <= idx[0];
    end
  end

  // Stage 2: palette lookup sees pre-write contents this clock.
  logic [3:0] nib;
  rgb_t       rgb_q;

  assign nib = odd_q ? vram.i_qv[7:4] : vram.i_qv[3:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= win_q ? pal[nib] : '0;
    end
  end

  // Two-deep delay lines: bit 0 = stage 1, bit 1 = stage 2.
  logic [1:0] de_d;
  logic [1:0] hs_d;
  logic [1:0] vs_d;
  logic [1:0] fs_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      de_d <= '0;
      hs_d <= {2{~SYNC_POL}};
      vs_d <= {2{~SYNC_POL}};
      fs_d <= '0;
    end else begin
      de_d <= {de_d[0], de0};
      hs_d <= {hs_d[0], hs0};
      vs_d <= {vs_d[0], vs0};
      fs_d <= {fs_d[0], fs0};
    end
  end

  assign o_de          = de_d[1];
  assign o_hsync       = hs_d[1];
  assign o_vsync       = vs_d[1];
  assign o_frame_start = fs_d[1];
  assign o_r           = rgb_q.r;
  assign o_g           = rgb_q.g;
  assign o_b           = rgb_q.b;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout on a shrunken raster (48x23 clocks,
// 8x4 image scaled x3) against a division-based reference model.
module tb_vram_scanout;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int S  = 3;
  localparam int HA = 32;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int VA = 16;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int AW = 4;

  localparam logic [23:0] VGA [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  widx = '0;
  logic [23:0] wdata = '0;
  logic        de, hs, vs, fs;
  logic [7:0]  r, g, b;

  vram_scanout_if #(.ADDRESS_WIDTH(AW)) vif ();

  vram_scanout #(
    .WIDTH (W), .HEIGHT (H), .SCALE (S),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .ADDRESS_WIDTH (AW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .vram          (vif),
    .i_pal_we      (we),
    .i_pal_idx     (widx),
    .i_pal_data    (wdata),
    .o_de          (de),
    .o_hsync       (hs),
    .o_vsync       (vs),
    .o_r           (r),
    .o_g           (g),
    .o_b           (b),
    .o_frame_start (fs)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];

  always @(posedge clk) vif.i_qv <= mem[vif.o_adrv];

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        win;
    logic [23:0] rgb;
    logic [31:0] idx;
  } pi_t;

  int checks = 0;
  int errors = 0;
  int h = 0, v = 0, hold = 0, cyc = 0;
  int last_fs = -1, hs_run = 0, vs_run = 0;
  logic [23:0] pal_m [16];
  pi_t p1, p2;

  function automatic logic win_f(int hh, int vv);
    return (hh < W * S) && (vv < H * S);
  endfunction

  function automatic int idx_f(int hh, int vv);
    return (vv / S) * W + hh / S;
  endfunction

  function automatic pi_t rst_item();
    pi_t p;
    p = '0;
    p.hs = 1'b1;
    p.vs = 1'b1;
    return p;
  endfunction

  function automatic pi_t st0(int hh, int vv);
    pi_t p;
    p = '0;
    p.de  = (hh < HA) && (vv < VA);
    p.hs  = !((hh >= HA + HF) && (hh < HA + HF + HS));
    p.vs  = !((vv >= VA + VF) && (vv < VA + VF + VS));
    p.fs  = (hh == 0) && (vv == 0);
    p.win = win_f(hh, vv);
    p.idx = idx_f(hh, vv);
    return p;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%h exp=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    pi_t c;
    logic m;
    int n;
    m = !rst && win_f(h, v);
    c = st0(h, v);
    @(posedge clk);
    if (rst) begin
      h = 0;
      v = 0;
      hold = 0;
      p1 = rst_item();
      p2 = rst_item();
      for (int i = 0; i < 16; i++) pal_m[i] = VGA[i];
      last_fs = -1;
      hs_run = 0;
      vs_run = 0;
    end else begin
      p2 = p1;
      if (p2.win) begin
        n = (p2.idx % 2 == 1) ? int'(mem[p2.idx / 2][7:4])
                              : int'(mem[p2.idx / 2][3:0]);
        p2.rgb = pal_m[n];
      end else begin
        p2.rgb = '0;
      end
      p1 = c;
      if (we) pal_m[widx] = wdata;
      if (m) hold = idx_f(h, v) / 2;
      if (h == HT - 1) begin
        h = 0;
        v = (v == VT - 1) ? 0 : v + 1;
      end else begin
        h++;
      end
    end
    cyc++;
    #1;
    m = !rst && win_f(h, v);
    chk("mev", vif.o_mev, m);
    chk("adrv", vif.o_adrv, m ? idx_f(h, v) / 2 : hold);
    chk("de", de, p2.de);
    chk("hsync", hs, p2.hs);
    chk("vsync", vs, p2.vs);
    chk("fstart", fs, p2.fs);
    chk("rgb", {r, g, b}, p2.rgb);
    if (!hs) begin
      hs_run++;
    end else begin
      if (hs_run > 0) chk("hs_len", hs_run, HS);
      hs_run = 0;
    end
    if (!vs) begin
      vs_run++;
    end else begin
      if (vs_run > 0) chk("vs_len", vs_run, VS * HT);
      vs_run = 0;
    end
    if (fs) begin
      if (last_fs >= 0) chk("fs_period", cyc - last_fs, HT * VT);
      last_fs = cyc;
    end
    if (!rst && h == W * S - 1 && v == H * S - 1)
      chk("last_adr", vif.o_adrv, (W * H - 1) / 2);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      pal_m[i] = VGA[i];
    end
    mem[0] = 8'h21;
    p1 = rst_item();
    p2 = rst_item();

    repeat (3) tick();
    rst = 1'b0;
    tick();
    tick();
    chk("fs_first", fs, 1);
    chk("px0_pal1", {r, g, b}, 24'h0000AA);
    repeat (3) tick();
    chk("px1_pal2", {r, g, b}, 24'h00AA00);

    repeat (2 * HT * VT + 50) tick();

    widx = 4'd1;
    wdata = 24'h123456;
    we = 1'b1;
    tick();
    we = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      we = ($urandom_range(0, 7) == 0);
      widx = 4'($urandom_range(0, 15));
      wdata = 24'($urandom);
      tick();
    end
    we = 1'b0;

    n = 0;
    while (!(h == 30 && v == 10) && n < 3 * HT * VT) begin
      tick();
      n++;
    end
    chk("seek_rst_point", (h == 30 && v == 10), 1);
    rst = 1'b1;
    tick();
    chk("rst_de", de, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_mev", vif.o_mev, 0);
    rst = 1'b0;
    tick();
    chk("rst_fs_early", fs, 0);
    tick();
    chk("rst_fs", fs, 1);
    chk("rst_px0", {r, g, b}, 24'h0000AA);

    repeat (HT * VT + 100) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
